// File: rtl/clock_div_sched.sv
// clock_div_sched: multi-channel programmable clock-divide scheduler
// Generates per-channel tick enables (one pulse every P cycles) and divided
// clocks (period 2P, 50% duty). All channels share one valid/ready config port.
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_cfg_valid   configuration request present
//   o_cfg_ready   request can be accepted this cycle
//   i_cfg_ch      target channel index
//   i_cfg_en      1 = start/restart channel, 0 = stop channel
//   i_cfg_period  divide period P (1..2^CNT_W-1)
//   o_cfg_err     one-cycle pulse after a rejected request
//   o_active      per-channel running flag
//   o_tick        per-channel enable pulse every P cycles
//   o_div_clock   per-channel divided clock
module clock_div_sched #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 17,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic              i_cfg_en,
   input  logic [CNT_W-1:0]  i_cfg_period,
   output logic              o_cfg_err,
   output logic [NUM_CH-1:0] o_active,
   output logic [NUM_CH-1:0] o_tick,
   output logic [NUM_CH-1:0] o_div_clock
);
   typedef enum logic {S_READY = 1'b0, S_BUSY = 1'b1} state_t;
   state_t r_state, w_next;
   logic   w_accept, w_ch_ok, w_bad, r_err;
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) r_state <= S_READY;
      else         r_state <= w_next;
   always_comb w_next = (r_state == S_READY && w_accept) ? S_BUSY : S_READY;
   always_comb o_cfg_ready = (r_state == S_READY);
   assign w_accept = i_cfg_valid && o_cfg_ready;
   // extra bit so NUM_CH itself is representable when it is a power of two
   assign w_ch_ok  = {1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH);
   assign w_bad    = !w_ch_ok || (i_cfg_en && i_cfg_period == '0);
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) r_err <= 1'b0;
      else         r_err <= w_accept && w_bad;
   assign o_cfg_err = r_err;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt, r_per;
      logic             r_act, r_div, w_wr;
      assign w_wr = w_accept && !w_bad && (i_cfg_ch == CH_W'(g));
      assign o_tick[g]      = r_act && (r_cnt == '0);
      assign o_active[g]    = r_act;
      assign o_div_clock[g] = r_div;
      // a config write takes priority over a coincident tick reload
      always_ff @(posedge i_clock or posedge i_reset)
         if (i_reset) begin
            r_act <= 1'b0;
            r_div <= 1'b0;
            r_cnt <= '0;
            r_per <= '0;
         end else if (w_wr) begin
            r_act <= i_cfg_en;
            r_div <= 1'b0;
            r_cnt <= i_cfg_en ? i_cfg_period - 1'b1 : '0;
            if (i_cfg_en) r_per <= i_cfg_period;
         end else if (o_tick[g]) begin
            r_cnt <= r_per - 1'b1;
            r_div <= ~r_div;
         end else if (r_act) begin
            r_cnt <= r_cnt - 1'b1;
         end
   end
endmodule

// File: tb/tb_clock_div_sched.sv
// tb_clock_div_sched: directed + random check of clock_div_sched against a cycle-arithmetic model
module tb_clock_div_sched;
   localparam int NUM_CH = 5;
   localparam int CNT_W  = 17;
   localparam int CH_W   = 3;
   logic clk = 1'b0, rst = 1'b1, v = 1'b0, en = 1'b0;
   logic [CH_W-1:0]   ch  = '0;
   logic [CNT_W-1:0]  per = '0;
   logic              rdy, err;
   logic [NUM_CH-1:0] act, tck, dvc;
   clock_div_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .i_clock(clk), .i_reset(rst), .i_cfg_valid(v), .o_cfg_ready(rdy),
      .i_cfg_ch(ch), .i_cfg_en(en), .i_cfg_period(per), .o_cfg_err(err),
      .o_active(act), .o_tick(tck), .o_div_clock(dvc)
   );
   always #5 clk = ~clk;
   int ncmp = 0, nbad = 0, cyc = 0;
   bit m_act [NUM_CH];
   int m_start [NUM_CH];
   int m_per [NUM_CH];
   bit m_busy, m_err;
   function automatic bit e_tick(int k);
      return m_act[k] && cyc > m_start[k] && (cyc - m_start[k]) % m_per[k] == 0;
   endfunction
   function automatic bit e_div(int k);
      return m_act[k] && ((cyc - m_start[k] - 1) / m_per[k]) % 2 == 1;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nbad++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   task automatic model_clear();
      for (int k = 0; k < NUM_CH; k++) begin
         m_act[k] = 0; m_start[k] = 0; m_per[k] = 1;
      end
      m_busy = 0; m_err = 0;
   endtask
   task automatic step();
      logic [NUM_CH-1:0] et, ea, ed;
      bit acc, bad;
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
         et[k] = e_tick(k); ea[k] = m_act[k]; ed[k] = e_div(k);
      end
      chk("tick", 32'(tck), 32'(et));
      chk("active", 32'(act), 32'(ea));
      chk("div_clock", 32'(dvc), 32'(ed));
      chk("cfg_ready", 32'(rdy), 32'(!m_busy));
      chk("cfg_err", 32'(err), 32'(m_err));
      acc = v && !m_busy;
      bad = acc && (int'(ch) >= NUM_CH || (en && per == 0));
      @(posedge clk);
      if (acc && !bad) begin
         if (en) begin
            m_act[int'(ch)] = 1; m_start[int'(ch)] = cyc; m_per[int'(ch)] = int'(per);
         end else m_act[int'(ch)] = 0;
      end
      m_err = bad; m_busy = acc; cyc++;
      #1;
   endtask
   task automatic idle(int n);
      repeat (n) step();
   endtask
   task automatic req(int c, bit e, int p);
      v = 1'b1; ch = CH_W'(c); en = e; per = CNT_W'(p);
      step();
      v = 1'b0;
   endtask
   task automatic do_reset();
      #2 rst = 1'b1;
      model_clear();
      #1;
      chk("rst_active", 32'(act), 0);
      chk("rst_tick", 32'(tck), 0);
      chk("rst_div", 32'(dvc), 0);
      chk("rst_ready", 32'(rdy), 1);
      chk("rst_err", 32'(err), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask
   initial begin
      model_clear();
      #1;
      chk("init_active", 32'(act), 0);
      chk("init_ready", 32'(rdy), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);
      req(0, 1, 4); idle(14);
      req(1, 1, 1); idle(1);
      req(2, 1, 0); idle(5);
      req(1, 0, 0); idle(1);
      req(0, 1, 3);
      for (int i = 0; i < 10 && !e_tick(0); i++) step();
      req(0, 1, 6); idle(14);
      req(0, 1, 3); idle(1);
      req(3, 1, 7); idle(20);
      req(3, 0, 0); idle(12);
      v = 1'b1; ch = 3'd0; en = 1'b1; per = 17'd2;
      step();
      ch = 3'd1; per = 17'd3;
      step(); step();
      v = 1'b0; idle(1);
      req(NUM_CH, 1, 5); idle(6);
      req(0, 1, 5); idle(7);
      do_reset();
      idle(12);
      repeat (600) begin
         v   = ($urandom_range(0, 2) == 0);
         ch  = CH_W'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         per = ($urandom_range(0, 4) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
         step();
      end
      v = 1'b0;
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
